// File: rtl/commit_trace.sv
// Commit trace: captures retired-instruction records into a FWFT FIFO. Records are visible 1 cycle after the post strobe.
// Backpressure via trace_ready; a push to a full FIFO with no pop is dropped. Optional timestamps: COMMIT_TRACE_TIMESTAMP_EN.
module commit_trace #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pre_execution,
  input  logic                     post_execution,
  input  logic [31:0]              pc_debug,
  input  logic                     clr,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_seq,
  output logic [31:0]              trace_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     proto_err,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state_q;
  logic            pre_q, post_q;
  logic [31:0]     pc_q;
  logic [31:0]     seq_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, proto_err_q;
  logic [15:0]     drop_cnt_q;

  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     seq_mem [DEPTH];

  logic pre_rise, post_rise, pop, push, full, wr_en, drop;

  always_comb begin
    pre_rise  = pre_execution & ~pre_q;
    post_rise = post_execution & ~post_q;
    pop       = (level_q != '0) & trace_ready;
    push      = (state_q == EXEC) & post_rise & ~pre_rise & ~clr;
    full      = (level_q == LW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_en     = push & (~full | pop);
    drop      = push & full & ~pop;
    level_d   = level_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pre_q       <= 1'b0;
      post_q      <= 1'b0;
      pc_q        <= '0;
      seq_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      pre_q  <= pre_execution;
      post_q <= post_execution;
      if (clr) begin
        state_q     <= IDLE;
        seq_q       <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        level_q     <= '0;
        overflow_q  <= 1'b0;
        proto_err_q <= 1'b0;
        drop_cnt_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_d;
        // Sequence advances even for dropped records so gaps show downstream.
        if (push) seq_q <= seq_q + 32'd1;
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
        case (state_q)
          IDLE: begin
            if (pre_rise && post_rise) begin
              proto_err_q <= 1'b1;
            end else if (pre_rise) begin
              pc_q    <= pc_debug;
              state_q <= EXEC;
            end else if (post_rise) begin
              proto_err_q <= 1'b1;
            end
          end
          EXEC: begin
            if (pre_rise && post_rise) begin
              proto_err_q <= 1'b1;
              state_q     <= IDLE;
            end else if (pre_rise) begin
              proto_err_q <= 1'b1;
              pc_q        <= pc_debug;
            end else if (post_rise) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]  <= pc_q;
      seq_mem[wr_ptr_q] <= seq_q;
    end
  end

  assign trace_valid = (level_q != '0);
  assign trace_pc    = trace_valid ? pc_mem[rd_ptr_q]  : 32'd0;
  assign trace_seq   = trace_valid ? seq_mem[rd_ptr_q] : 32'd0;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;
  assign drop_cnt    = drop_cnt_q;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ts_q <= '0;
    else if (clr) ts_q <= '0;
    else          ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign trace_ts = trace_valid ? ts_mem[rd_ptr_q] : 32'd0;
`else
  assign trace_ts = 32'd0;
`endif

endmodule

// File: tb/tb_commit_trace.sv
// Scoreboard bench for commit_trace: expected records queued at retire, checked on pop.
module tb_commit_trace;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] seq;
    logic [31:0] ts;
  } rec_t;

  logic        clk, rst;
  logic        pre_execution, post_execution, clr, trace_ready;
  logic [31:0] pc_debug;
  logic        trace_valid, overflow, proto_err;
  logic [31:0] trace_pc, trace_seq, trace_ts;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  int          total = 0;
  int          bad   = 0;
  rec_t        exp_q[$];
  logic [31:0] exp_seq;
  logic [31:0] cyc;
  logic [31:0] t0, t1;

  commit_trace #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pre_execution(pre_execution), .post_execution(post_execution),
    .pc_debug(pc_debug), .clr(clr), .trace_ready(trace_ready),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_seq(trace_seq),
    .trace_ts(trace_ts), .level(level), .overflow(overflow),
    .proto_err(proto_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: the value a record captures is the count seen when post is driven.
  always @(posedge clk or negedge rst) begin
    if (!rst)     cyc <= 32'd0;
    else if (clr) cyc <= 32'd0;
    else          cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] pc);
    rec_t r;
    r.pc  = pc;
    r.seq = exp_seq;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    r.ts  = cyc;
`else
    r.ts  = 32'd0;
`endif
    if (exp_q.size() < DEPTH || (trace_ready && exp_q.size() > 0))
      exp_q.push_back(r);
    exp_seq = exp_seq + 32'd1;
  endtask

  task automatic retire(input logic [31:0] pc);
    pre_execution = 1'b1;
    pc_debug      = pc;
    tick();
    pre_execution = 1'b0;
    tick();
    post_execution = 1'b1;
    sb_push(pc);
    tick();
    post_execution = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    exp_q.delete();
    exp_seq = 32'd0;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain();
    trace_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    trace_ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (rst && !clr && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("rec_pc", trace_pc, r.pc);
        check("rec_seq", trace_seq, r.seq);
        check("rec_ts", trace_ts, r.ts);
      end
    end
  end

  initial begin
    rst = 1'b0; pre_execution = 1'b0; post_execution = 1'b0;
    pc_debug = 32'd0; clr = 1'b0; trace_ready = 1'b0; exp_seq = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_pc", trace_pc, 32'd0);
    check("rst_seq", trace_seq, 32'd0);
    check("rst_ts", trace_ts, 32'd0);
    rst = 1'b1;
    tick();

    // Single retire with consumer ready
    trace_ready = 1'b1;
    pre_execution = 1'b1; pc_debug = 32'h10;
    tick();
    pre_execution = 1'b0;
    tick();
    post_execution = 1'b1;
    sb_push(32'h10);
    tick();
    post_execution = 1'b0;
    check("single_level1", 32'(level), 32'd1);
    check("single_valid1", 32'(trace_valid), 32'd1);
    tick();
    check("single_level0", 32'(level), 32'd0);
    check("single_valid0", 32'(trace_valid), 32'd0);
    trace_ready = 1'b0;

    // Fill past capacity
    do_clr();
    for (int i = 0; i < 18; i++) retire(32'h100 + 32'(i) * 4);
    check("fill_level", 32'(level), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_drop", 32'(drop_cnt), 32'd2);
    check("fill_head_seq", trace_seq, 32'd0);
    drain();

    // Full with simultaneous pop
    do_clr();
    for (int i = 0; i < 16; i++) retire(32'h300 + 32'(i) * 4);
    check("fullpop_pre_level", 32'(level), 32'd16);
    pre_execution = 1'b1; pc_debug = 32'h200;
    tick();
    pre_execution = 1'b0;
    tick();
    post_execution = 1'b1;
    trace_ready = 1'b1;
    sb_push(32'h200);
    tick();
    post_execution = 1'b0;
    trace_ready = 1'b0;
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    drain();

    // Protocol violations
    do_clr();
    post_execution = 1'b1;
    tick();
    post_execution = 1'b0;
    tick();
    check("orphan_post_proto", 32'(proto_err), 32'd1);
    check("orphan_post_level", 32'(level), 32'd0);
    do_clr();
    pre_execution = 1'b1; pc_debug = 32'h1c;
    tick();
    pre_execution = 1'b0;
    tick();
    pre_execution = 1'b1; pc_debug = 32'h20;
    tick();
    pre_execution = 1'b0;
    tick();
    post_execution = 1'b1;
    sb_push(32'h20);
    tick();
    post_execution = 1'b0;
    tick();
    check("double_pre_proto", 32'(proto_err), 32'd1);
    check("double_pre_level", 32'(level), 32'd1);
    drain();

    // Pre and post rising together in EXEC
    do_clr();
    pre_execution = 1'b1; pc_debug = 32'h28;
    tick();
    pre_execution = 1'b0;
    tick();
    pre_execution = 1'b1; post_execution = 1'b1;
    tick();
    pre_execution = 1'b0; post_execution = 1'b0;
    tick();
    check("both_level", 32'(level), 32'd0);
    check("both_proto", 32'(proto_err), 32'd1);
    retire(32'h30);
    check("both_then_retire_level", 32'(level), 32'd1);
    drain();

    // Asynchronous reset during EXEC
    pre_execution = 1'b1; pc_debug = 32'h40;
    tick();
    pre_execution = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_seq = 32'd0;
    #2;
    check("arst_valid", 32'(trace_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_proto", 32'(proto_err), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_pc", trace_pc, 32'd0);
    check("arst_seq", trace_seq, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    post_execution = 1'b1;
    tick();
    post_execution = 1'b0;
    tick();
    check("arst_post_level", 32'(level), 32'd0);
    check("arst_post_valid", 32'(trace_valid), 32'd0);
    check("arst_post_proto", 32'(proto_err), 32'd1);

    // Clear at level 5, then clear overriding a push
    do_clr();
    check("clr_proto", 32'(proto_err), 32'd0);
    for (int i = 0; i < 5; i++) retire(32'h500 + 32'(i) * 4);
    check("clr_pre_level", 32'(level), 32'd5);
    do_clr();
    check("clr_level", 32'(level), 32'd0);
    check("clr_valid", 32'(trace_valid), 32'd0);
    pre_execution = 1'b1; pc_debug = 32'h600;
    tick();
    pre_execution = 1'b0;
    tick();
    post_execution = 1'b1;
    do_clr();
    post_execution = 1'b0;
    tick();
    check("clr_override_level", 32'(level), 32'd0);
    retire(32'h604);
    check("clr_after_seq", trace_seq, 32'd0);
    drain();

    // Timestamp capture
    do_clr();
    retire(32'h50);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    repeat (3) tick();
    retire(32'h54);
    check("ts_level", 32'(level), 32'd2);
    t0 = trace_ts;
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    t1 = trace_ts;
    check("ts_delta", t1 - t0, 32'd7);
`else
    check("ts_off_valid", 32'(trace_valid), 32'd1);
    check("ts_off_zero", trace_ts, 32'd0);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
